// File: rtl/viterbi_burst_channel_if.sv
// Symbol stream into and out of the burst-error channel, plus its statistics.
interface viterbi_burst_channel_if;
  logic        valid_i;
  logic [1:0]  sym_i;
  logic        inject_en_i;
  logic        force_i;
  logic        valid_o;
  logic [1:0]  sym_o;
  logic [1:0]  err_mask_o;
  logic        burst_active_o;
  logic [15:0] word_ct_o;
  logic [15:0] flip_ct_o;
  logic [15:0] burst_ct_o;

  modport master (
    output valid_i, sym_i, inject_en_i, force_i,
    input  valid_o, sym_o, err_mask_o, burst_active_o,
    input  word_ct_o, flip_ct_o, burst_ct_o
  );

  modport slave (
    input  valid_i, sym_i, inject_en_i, force_i,
    output valid_o, sym_o, err_mask_o, burst_active_o,
    output word_ct_o, flip_ct_o, burst_ct_o
  );
endinterface

// File: rtl/viterbi_burst_channel.sv
// Burst-error channel between convolutional encoder and Viterbi decoder.
// Optional macro CHANNEL_SINGLE_BIT_EN: corrupt one LFSR-chosen bit instead of both.
module viterbi_burst_channel #(
  parameter int          N         = 4,
  parameter int          BURST_LEN = 1,
  parameter int          GUARD_LEN = 0,
  parameter int          WINDOW    = 256,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  viterbi_burst_channel_if.slave   bus
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_BURST  = 2'd1;
  localparam logic [1:0]  S_GUARD  = 2'd2;
  localparam logic [15:0] TAPS     = 16'hB400;
  localparam logic [7:0]  BL_U     = 8'(BURST_LEN);
  localparam logic [7:0]  GL_U     = 8'(GUARD_LEN);
  localparam logic [31:0] WINDOW_U = WINDOW;

  logic [1:0]  r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [15:0] r_lfsr, w_lfsr_nxt;
  logic [15:0] r_word_ct, r_flip_ct, r_burst_ct;
  logic        r_vld_p0;
  logic [1:0]  r_sym_p0, r_mask_p0;
  logic        w_trig, w_corrupt, w_in_window;
  logic [1:0]  w_hit_mask, w_mask;

  function automatic logic [1:0] popcnt2(input logic [1:0] m);
    return {1'b0, m[1]} + {1'b0, m[0]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

`ifdef CHANNEL_SINGLE_BIT_EN
  assign w_hit_mask = r_lfsr[15] ? 2'b01 : 2'b10;
`else
  assign w_hit_mask = 2'b11;
`endif

  assign w_in_window = ({16'd0, r_word_ct} < WINDOW_U);
  // Trigger looks at the LFSR value before this symbol advances it.
  assign w_trig      = ((&r_lfsr[N-1:0]) | bus.force_i) & bus.inject_en_i & bus.valid_i
                       & w_in_window & (r_state == S_IDLE);
  assign w_lfsr_nxt  = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 16'h0000);
  assign w_mask      = w_corrupt ? w_hit_mask : 2'b00;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_corrupt   = 1'b0;
    if (!bus.inject_en_i) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 8'd0;
    end else if (bus.valid_i) begin
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            w_corrupt = 1'b1;
            w_cnt_nxt = 8'd0;
            if (BL_U > 8'd1) begin
              w_state_nxt = S_BURST;
              w_cnt_nxt   = 8'd1;
            end else if (GL_U != 8'd0) begin
              w_state_nxt = S_GUARD;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_BURST: begin
          w_corrupt = 1'b1;
          w_cnt_nxt = r_cnt + 8'd1;
          if (r_cnt + 8'd1 == BL_U) begin
            w_cnt_nxt   = 8'd0;
            w_state_nxt = (GL_U != 8'd0) ? S_GUARD : S_IDLE;
          end
        end
        S_GUARD: begin
          w_cnt_nxt = r_cnt + 8'd1;
          if (r_cnt + 8'd1 == GL_U) begin
            w_cnt_nxt   = 8'd0;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  // Stage p0: registered symbol, mask and valid; statistics advance on valid symbols only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_lfsr     <= SEED;
      r_word_ct  <= 16'd0;
      r_flip_ct  <= 16'd0;
      r_burst_ct <= 16'd0;
      r_vld_p0   <= 1'b0;
      r_sym_p0   <= 2'b00;
      r_mask_p0  <= 2'b00;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_vld_p0  <= bus.valid_i;
      r_sym_p0  <= bus.sym_i ^ w_mask;
      r_mask_p0 <= w_mask;
      if (bus.valid_i) begin
        r_lfsr    <= w_lfsr_nxt;
        r_word_ct <= sat_inc(r_word_ct, 2'd1);
        r_flip_ct <= sat_inc(r_flip_ct, popcnt2(w_mask));
        if (w_trig) r_burst_ct <= sat_inc(r_burst_ct, 2'd1);
      end
    end
  end

  assign bus.valid_o        = r_vld_p0;
  assign bus.sym_o          = r_sym_p0;
  assign bus.err_mask_o     = r_mask_p0;
  assign bus.burst_active_o = (r_state == S_BURST);
  assign bus.word_ct_o      = r_word_ct;
  assign bus.flip_ct_o      = r_flip_ct;
  assign bus.burst_ct_o     = r_burst_ct;

endmodule

// File: tb/tb_viterbi_burst_channel.sv
// Bench for viterbi_burst_channel: three parameterisations driven in lock-step
// against a remaining-symbol-count reference model.
module tb_viterbi_burst_channel;

  localparam int P_N  [3] = '{16, 2, 3};
  localparam int P_BL [3] = '{3, 1, 5};
  localparam int P_GL [3] = '{2, 0, 3};
  localparam int P_W  [3] = '{256, 4, 256};
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic       t_valid = 1'b0;
  logic [1:0] t_sym   = 2'b00;
  logic       t_inj   = 1'b0;
  logic       t_force = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  viterbi_burst_channel_if ifa ();
  viterbi_burst_channel_if ifb ();
  viterbi_burst_channel_if ifc ();

  assign ifa.valid_i = t_valid;  assign ifa.sym_i = t_sym;
  assign ifa.inject_en_i = t_inj; assign ifa.force_i = t_force;
  assign ifb.valid_i = t_valid;  assign ifb.sym_i = t_sym;
  assign ifb.inject_en_i = t_inj; assign ifb.force_i = t_force;
  assign ifc.valid_i = t_valid;  assign ifc.sym_i = t_sym;
  assign ifc.inject_en_i = t_inj; assign ifc.force_i = t_force;

  viterbi_burst_channel #(.N(16), .BURST_LEN(3), .GUARD_LEN(2), .WINDOW(256), .SEED(SEED))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  viterbi_burst_channel #(.N(2), .BURST_LEN(1), .GUARD_LEN(0), .WINDOW(4), .SEED(SEED))
    u_b (.clk(clk), .rst(rst), .bus(ifb));
  viterbi_burst_channel #(.N(3), .BURST_LEN(5), .GUARD_LEN(3), .WINDOW(256), .SEED(SEED))
    u_c (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  // Reference model: bursts tracked as "symbols still to corrupt / still to guard".
  int          m_bl [3];
  int          m_gl [3];
  logic [15:0] m_lfsr [3];
  logic [15:0] m_word [3];
  logic [15:0] m_flip [3];
  logic [15:0] m_bursts [3];
  logic        m_vld [3];
  logic [1:0]  m_sym [3];
  logic [1:0]  m_mask [3];

  function automatic logic [15:0] sat_add(input logic [15:0] a, input int b);
    int s;
    s = int'(a) + b;
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  function automatic logic [1:0] hit_mask(input int k);
`ifdef CHANNEL_SINGLE_BIT_EN
    return (m_lfsr[k] >= 16'h8000) ? 2'b01 : 2'b10;
`else
    return 2'b11;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_bl[k] = 0; m_gl[k] = 0; m_lfsr[k] = SEED;
      m_word[k] = 0; m_flip[k] = 0; m_bursts[k] = 0;
      m_vld[k] = 0; m_sym[k] = 0; m_mask[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic v, input logic [1:0] s,
                            input logic inj, input logic f);
    logic [1:0] mask;
    int ones;
    int lv;
    mask = 2'b00;
    ones = (1 << P_N[k]) - 1;
    lv   = int'(m_lfsr[k]);
    if (!inj) begin
      m_bl[k] = 0;
      m_gl[k] = 0;
    end else if (v) begin
      if (m_bl[k] > 0) begin
        mask = hit_mask(k);
        m_bl[k]--;
        if (m_bl[k] == 0) m_gl[k] = P_GL[k];
      end else if (m_gl[k] > 0) begin
        m_gl[k]--;
      end else if ((((lv & ones) == ones) || f) && (int'(m_word[k]) < P_W[k])) begin
        mask = hit_mask(k);
        m_bursts[k] = sat_add(m_bursts[k], 1);
        m_bl[k] = P_BL[k] - 1;
        if (m_bl[k] == 0) m_gl[k] = P_GL[k];
      end
    end
    if (v) begin
      m_word[k] = sat_add(m_word[k], 1);
      m_flip[k] = sat_add(m_flip[k], $countones(mask));
      m_lfsr[k] = 16'((lv / 2) ^ ((lv % 2 == 1) ? 32'hB400 : 32'h0));
    end
    m_vld[k]  = v;
    m_sym[k]  = s ^ mask;
    m_mask[k] = mask;
  endtask

  function automatic logic [53:0] exp_vec(input int k);
    return {m_vld[k], m_sym[k], m_mask[k], (m_bl[k] > 0), m_word[k], m_flip[k], m_bursts[k]};
  endfunction

  function automatic logic [53:0] dut_vec(input int k);
    case (k)
      0: return {ifa.valid_o, ifa.sym_o, ifa.err_mask_o, ifa.burst_active_o,
                 ifa.word_ct_o, ifa.flip_ct_o, ifa.burst_ct_o};
      1: return {ifb.valid_o, ifb.sym_o, ifb.err_mask_o, ifb.burst_active_o,
                 ifb.word_ct_o, ifb.flip_ct_o, ifb.burst_ct_o};
      default: return {ifc.valid_o, ifc.sym_o, ifc.err_mask_o, ifc.burst_active_o,
                       ifc.word_ct_o, ifc.flip_ct_o, ifc.burst_ct_o};
    endcase
  endfunction

  // Apply one cycle of stimulus, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [1:0] s, input logic inj, input logic f);
    t_valid = v; t_sym = s; t_inj = inj; t_force = f;
    for (int k = 0; k < 3; k++) model_step(k, v, s, inj, f);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    t_valid = 1'b0; t_inj = 1'b0; t_force = 1'b0; t_sym = 2'b00;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (dut_vec(k) !== exp_vec(k)) begin
        miscompares++;
        $display("FAIL reset inst%0d: got %h want %h", k, dut_vec(k), exp_vec(k));
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_passthrough();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (dut_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL passthrough inst%0d cyc%0d: got %h want %h", k, i, dut_vec(k), exp_vec(k));
        end
      end
    end
    vectors++;
    if ({ifa.word_ct_o, ifa.flip_ct_o, ifa.burst_ct_o} !== {16'd300, 16'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL passthrough_counts: got %0d/%0d/%0d want 300/0/0",
               ifa.word_ct_o, ifa.flip_ct_o, ifa.burst_ct_o);
    end
  endtask

  task automatic test_force_burst();
    logic [15:0] want_flip;
    logic f;
`ifdef CHANNEL_SINGLE_BIT_EN
    want_flip = 16'd3;
`else
    want_flip = 16'd6;
`endif
    apply_reset();
    // force pulse, two further burst symbols, two guard symbols with force, then idle
    for (int i = 0; i < 6; i++) begin
      f = (i == 0 || i == 3 || i == 4);
      step(1'b1, 2'b00, 1'b1, f);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (dut_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL force_burst inst%0d cyc%0d: got %h want %h", k, i, dut_vec(k), exp_vec(k));
        end
      end
    end
    vectors++;
    if (ifa.burst_ct_o !== 16'd1 || ifa.flip_ct_o !== want_flip) begin
      miscompares++;
      $display("FAIL force_burst_counts: got bursts %0d flips %0d want 1 %0d",
               ifa.burst_ct_o, ifa.flip_ct_o, want_flip);
    end
  endtask

  task automatic test_valid_gaps();
    int hits;
    hits = 0;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step((i % 2 == 0) || (i > 5), 2'b01, 1'b1, (i == 0));
      if (ifa.valid_o && ifa.err_mask_o != 2'b00) hits++;
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (dut_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL valid_gaps inst%0d cyc%0d: got %h want %h", k, i, dut_vec(k), exp_vec(k));
        end
      end
    end
    vectors++;
    if (hits != 3) begin
      miscompares++;
      $display("FAIL valid_gaps_hits: got %0d corrupted symbols want 3", hits);
    end
  endtask

  task automatic test_window();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 2'($urandom), 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (dut_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL window inst%0d cyc%0d: got %h want %h", k, i, dut_vec(k), exp_vec(k));
        end
      end
    end
    vectors++;
    if (ifb.burst_ct_o !== 16'd4) begin
      miscompares++;
      $display("FAIL window_bursts: got %0d want 4", ifb.burst_ct_o);
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    step(1'b1, 2'b00, 1'b1, 1'b1);
    step(1'b1, 2'b00, 1'b1, 1'b0);
    rst = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (dut_vec(k) !== exp_vec(k)) begin
        miscompares++;
        $display("FAIL reset_mid_burst inst%0d: got %h want %h", k, dut_vec(k), exp_vec(k));
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 2'b10, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (dut_vec(k) !== exp_vec(k)) begin
        miscompares++;
        $display("FAIL after_reset inst%0d: got %h want %h", k, dut_vec(k), exp_vec(k));
      end
    end
    vectors++;
    if (ifc.sym_o !== 2'b10 || ifc.err_mask_o !== 2'b00) begin
      miscompares++;
      $display("FAIL after_reset_clean: got sym %b mask %b want 10 00", ifc.sym_o, ifc.err_mask_o);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, 2'($urandom), ($urandom % 16) != 0, ($urandom % 20) == 0);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (dut_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL random inst%0d cyc%0d: got %h want %h", k, i, dut_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_force_burst();
    test_valid_gaps();
    test_window();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
